// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: post-reset clear sweep, round-robin
// arbitration between ALU (A) and load (B) write-back, pending-write
// scoreboard and a saturating lost-arbitration counter.
`timescale 1ns/1ps

module regfile_wb_arbiter #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned STALL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               a_valid,
    output logic               a_ready,
    input  logic [4:0]         a_rd,
    input  logic [XLEN-1:0]    a_data,
    input  logic               b_valid,
    output logic               b_ready,
    input  logic [4:0]         b_rd,
    input  logic [XLEN-1:0]    b_data,
    input  logic               alloc_valid,
    input  logic [4:0]         alloc_rd,
    output logic               rf_we,
    output logic [4:0]         rf_rd,
    output logic [XLEN-1:0]    rf_wdata,
    output logic [31:0]        busy,
    output logic               init_done,
    output logic [STALL_W-1:0] stall_cnt
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state;
    logic [4:0]        init_cnt;     // next register to clear; wraps to 0 after x31
    logic              rr_prefer_b;  // set after A wins, so B gets the next contested cycle
    logic              a_acc;
    logic              b_acc;
    logic              acc;
    logic [4:0]        acc_rd;
    logic [XLEN-1:0]   acc_data;
    logic              lost;
    logic [31:0]       busy_nxt;

    // Combinational grants; nothing is granted while the clear sweep runs
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (state == ST_RUN) begin
            if (a_valid && b_valid) begin
                a_ready = !rr_prefer_b;
                b_ready = rr_prefer_b;
            end else begin
                a_ready = a_valid;
                b_ready = b_valid;
            end
        end
    end

    // Accepted transfer selection and lost-arbitration detection
    always_comb begin
        a_acc    = a_valid && a_ready;
        b_acc    = b_valid && b_ready;
        acc      = a_acc || b_acc;
        acc_rd   = b_acc ? b_rd   : a_rd;
        acc_data = b_acc ? b_data : a_data;
        lost     = (state == ST_RUN) &&
                   ((a_valid && !a_ready) || (b_valid && !b_ready));
    end

    // Scoreboard update: write-back clears, allocation sets and wins a tie
    always_comb begin
        busy_nxt = busy;
        if (acc && (acc_rd != 5'd0)) begin
            busy_nxt[acc_rd] = 1'b0;
        end
        if ((state == ST_RUN) && alloc_valid && (alloc_rd != 5'd0)) begin
            busy_nxt[alloc_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // State, sweep counter, registered write port, scoreboard and stall counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_INIT;
            init_cnt    <= 5'd1;
            rr_prefer_b <= 1'b0;
            rf_we       <= 1'b0;
            rf_rd       <= 5'd0;
            rf_wdata    <= '0;
            busy        <= '0;
            init_done   <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (init_cnt == 5'd0) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                        rf_we     <= 1'b0;
                    end else begin
                        rf_we    <= 1'b1;
                        rf_rd    <= init_cnt;
                        rf_wdata <= '0;
                        init_cnt <= init_cnt + 5'd1;
                    end
                end
                ST_RUN: begin
                    rf_we <= acc && (acc_rd != 5'd0);
                    if (acc) begin
                        rf_rd       <= acc_rd;
                        rf_wdata    <= acc_data;
                        rr_prefer_b <= a_acc;
                    end
                    busy <= busy_nxt;
                    if (lost && (stall_cnt != {STALL_W{1'b1}})) begin
                        stall_cnt <= stall_cnt + STALL_W'(1);
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule
